// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the pipeline memory stage and a word-organised
// data memory without byte enables. Sub-word stores are read-modify-write.
// Misaligned, out-of-range and illegal accesses return an error response
// and never touch memory.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic [31:0]       i_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_RMW_RD,
    S_WR,
    S_RSP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t            state;
  state_t            state_nxt;

  // Registered request fields; only the in-range address bits are kept.
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic              err_q;
  // Holds wdata after acceptance, then the merged word after RMW_RD.
  logic [31:0]       wr_word_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_err;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [31:0]       merged;

  assign accept = i_req_valid && (state == S_IDLE);

  // Classify the incoming request; any error skips the memory entirely.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    req_err = |i_req_addr[31:ADDR_W+2];
    unique case (i_req_funct3)
      F3_B:    ;
      F3_H:    if (i_req_addr[0]) req_err = 1'b1;
      F3_W:    if (i_req_addr[1:0] != 2'b00) req_err = 1'b1;
      F3_BU:   if (i_req_we) req_err = 1'b1;
      F3_HU:   if (i_req_we || i_req_addr[0]) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                    state_nxt = S_RSP;
          else if (!i_req_we)             state_nxt = S_LD;
          else if (i_req_funct3 == F3_W)  state_nxt = S_WR;
          else                            state_nxt = S_RMW_RD;
        end
      end
      S_LD:     state_nxt = S_RSP;
      S_RMW_RD: state_nxt = S_WR;
      S_WR:     state_nxt = S_RSP;
      S_RSP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Lane selection and extension of the loaded word.
  always_comb begin
    ld_byte = i_mem_data[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    unique case (f3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {24'h0, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {16'h0, ld_half};
      default: ld_ext = i_mem_data;
    endcase
  end

  // Insert the store byte/halfword into the read word; other lanes untouched.
  always_comb begin
    merged = i_mem_data;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wr_word_q[15:0];
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wr_word_q[7:0];
  end

  // Request capture, merge and result registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      f3_q      <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        f3_q      <= i_req_funct3;
        addr_q    <= i_req_addr[ADDR_W+1:0];
        err_q     <= req_err;
        wr_word_q <= i_req_wdata;
        if (req_err) rdata_q <= '0;
      end
      unique case (state)
        S_LD:     rdata_q   <= ld_ext;
        S_RMW_RD: wr_word_q <= merged;
        S_WR:     rdata_q   <= '0;
        default:  ;
      endcase
    end
  end

  // Outputs decoded from state so reset drops a pending write at once.
  always_comb begin
    o_req_ready = (state == S_IDLE);
    o_rsp_valid = (state == S_RSP);
    o_rsp_err   = (state == S_RSP) && err_q;
    o_mem_write = (state == S_WR);
    o_mem_data  = (state == S_WR) ? wr_word_q : 32'h0;
    o_mem_addr  = addr_q[ADDR_W+1:2];
    o_rsp_rdata = rdata_q;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting between the RISC-V pipeline's memory stage and the word-organised data_memory.
- Pipeline side: byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready request and a one-cycle response pulse.
- Memory side: drives data_memory's word interface. SB and SH are done as read-modify-write, because data_memory has no byte enables.
- Also flags misaligned, out-of-range and illegal accesses.

Parameters:
- ADDR_W, 11, data_memory word-address width; byte space is 4*2^ADDR_W bytes (8192 at default).

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE; a request is accepted on an edge where valid&&ready.
- i_req_we  in  1  1=store, 0=load.
- i_req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  32  load result (extended); 0 for stores and errors.
- o_rsp_err  out  1  valid with o_rsp_valid; misaligned, out-of-range or illegal funct3.
- o_mem_write  out  1  data_memory write enable.
- o_mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2].
- o_mem_data  out  32  word write data.
- i_mem_data  in  32  data_memory read data; combinational from o_mem_addr. Writes commit on the rising edge while o_mem_write=1.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - o_req_ready=1; o_rsp_valid, o_rsp_err and o_mem_write = 0.
  - o_rsp_rdata, o_mem_addr and o_mem_data = 0.
- Acceptance: on the accept edge, register we, funct3, addr and wdata. i_req_* are ignored at all other times.
- Error check at acceptance (any true → ERR path, no memory access):
  - addr[31:ADDR_W+2]!=0.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - Store with funct3 100 or 101.
- States: IDLE, LD, RMW_RD, WR, RSP.
  - IDLE → LD for a load.
  - IDLE → WR for SW.
  - IDLE → RMW_RD for SB/SH.
  - IDLE → RSP for an error.
  - LD → RSP.
  - RMW_RD → WR.
  - WR → RSP.
  - RSP → IDLE.
- o_mem_write is decoded from state: high exactly for the single cycle in WR.
- o_mem_addr is held stable from LD/RMW_RD through WR.
- LD: capture i_mem_data into the result register.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- RMW_RD: capture i_mem_data and merge the store byte/halfword into the addressed lane. Other lanes are kept bit-exact.
- WR: o_mem_data = merged word (SB/SH) or wdata (SW).
- RSP: o_rsp_valid=1 for exactly one cycle; o_rsp_err is set on the error path.
- Latency from the accept edge to the o_rsp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- o_req_ready=0 from the accept edge until the IDLE state is re-entered. No back-to-back acceptance; the earliest next accept is the edge ending the RSP cycle + 1.
- o_rsp_rdata holds its value until the next response.
- Reset mid-operation: returns to IDLE immediately. o_mem_write drops asynchronously, so a write whose edge has not yet occurred is aborted. No response is emitted for the aborted request.
- i_req_valid asserted during busy states: no effect and not queued. The request must be held until ready.

Test Plan:
- Reset mid-WR: assert i_rstn=0 during the WR cycle → o_mem_write drops immediately, memory word unchanged, no o_rsp_valid, o_req_ready=1.
- SW addr 0x000, data 0xA5A5A5A5, then LW 0x000:
  - o_mem_write pulses 1 cycle with o_mem_addr=0.
  - LW returns 0xA5A5A5A5; o_rsp_valid 2 cycles after each accept; err=0.
- SW 0x004 = 0xDEADBEEF, then SB 0x006 wdata 0x12:
  - Word 1 becomes 0xDE12BEEF.
  - LB 0x007 → 0xFFFFFFDE; LBU 0x007 → 0x000000DE.
- SH 0x102E wdata 0x8001 (word 1035, upper half), then:
  - LH 0x102E → 0xFFFF8001.
  - LHU → 0x00008001.
  - LW 0x102C → 0x8001xxxx, with the lower half unchanged.
- Errors: LW 0x002, SH 0x003, LB 0x2000 (out of range), store funct3=100:
  - Each gives o_rsp_err=1 and o_rsp_rdata=0, 1 cycle after accept.
  - o_mem_write never asserted; memory unchanged.
- Handshake: hold i_req_valid high with back-to-back requests → each accepted only when o_req_ready=1, responses in order, no request dropped or duplicated.
